// File: rtl/qmu_stream.sv
// Forward quality quantizer: divides samples by 2^mode with round-half-away-from-zero, mode frozen per frame.
// 2-cycle latency, 1 sample/cycle; optional per-frame zeroed-sample statistic under QMU_STATS_EN.
module qmu_stream #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [1:0]        quality_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        mode_active,
  output logic [CNT_W-1:0]  frame_zero_cnt
);

  typedef enum logic {START, IN_FRAME} state_e;

  state_e            state_q, state_d;
  logic [1:0]        mode_active_q, mode_active_d;
  logic              s1_vld_q, s1_vld_d;
  logic              s1_sign_q, s1_sign_d;
  logic              s1_last_q, s1_last_d;
  logic [1:0]        s1_mode_q, s1_mode_d;
  logic [DATA_W:0]   s1_sum_q, s1_sum_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              en, in_fire;
  logic [1:0]        cur_mode;
  logic [DATA_W:0]   x_ext, abs_x, rnd;
  logic [DATA_W-1:0] q;

`ifdef QMU_STATS_EN
  logic              s1_nz_q, s1_nz_d;
  logic              out_nz_q, out_nz_d;
  logic [CNT_W-1:0]  zcnt_q, zcnt_d;
  logic [CNT_W-1:0]  fzc_q, fzc_d;
  logic [CNT_W-1:0]  zsum;
  logic              zinc;
`endif

  always_comb begin
    en       = !out_valid_q || out_ready;
    in_fire  = in_valid && en;
    cur_mode = (state_q == START) ? quality_mode : mode_active_q;

    x_ext = {in_data[DATA_W-1], in_data};
    abs_x = in_data[DATA_W-1] ? -x_ext : x_ext;
    rnd   = '0;
    if (cur_mode != 2'd0) rnd[cur_mode - 2'd1] = 1'b1;

    // |x| + round never exceeds 2^(DATA_W-1) + 4, so the top bit is always clear here
    q = DATA_W'(s1_sum_q >> s1_mode_q);

    state_d       = state_q;
    mode_active_d = mode_active_q;
    s1_vld_d      = s1_vld_q;
    s1_sign_d     = s1_sign_q;
    s1_last_d     = s1_last_q;
    s1_mode_d     = s1_mode_q;
    s1_sum_d      = s1_sum_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    out_data_d    = out_data_q;

    if (en) begin
      s1_vld_d    = in_fire;
      out_valid_d = s1_vld_q;
      if (in_fire) begin
        s1_sign_d = in_data[DATA_W-1];
        s1_last_d = in_last;
        s1_mode_d = cur_mode;
        s1_sum_d  = abs_x + rnd;
      end
      if (s1_vld_q) begin
        out_data_d = s1_sign_q ? -q : q;
        out_last_d = s1_last_q;
      end
    end

    if (in_fire) begin
      if (state_q == START) mode_active_d = quality_mode;
      state_d = in_last ? START : IN_FRAME;
    end

`ifdef QMU_STATS_EN
    s1_nz_d  = s1_nz_q;
    out_nz_d = out_nz_q;
    zcnt_d   = zcnt_q;
    fzc_d    = fzc_q;
    if (en && in_fire)  s1_nz_d  = |in_data;
    if (en && s1_vld_q) out_nz_d = s1_nz_q;
    zinc = out_nz_q && (out_data_q == '0);
    zsum = (zcnt_q == '1) ? zcnt_q : zcnt_q + CNT_W'(zinc);
    if (out_valid_q && out_ready) begin
      if (out_last_q) begin
        fzc_d  = zsum;
        zcnt_d = '0;
      end else begin
        zcnt_d = zsum;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= START;
      mode_active_q <= 2'd0;
      s1_vld_q      <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_mode_q     <= 2'd0;
      s1_sum_q      <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
`ifdef QMU_STATS_EN
      s1_nz_q       <= 1'b0;
      out_nz_q      <= 1'b0;
      zcnt_q        <= '0;
      fzc_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mode_active_q <= mode_active_d;
      s1_vld_q      <= s1_vld_d;
      s1_sign_q     <= s1_sign_d;
      s1_last_q     <= s1_last_d;
      s1_mode_q     <= s1_mode_d;
      s1_sum_q      <= s1_sum_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_data_q    <= out_data_d;
`ifdef QMU_STATS_EN
      s1_nz_q       <= s1_nz_d;
      out_nz_q      <= out_nz_d;
      zcnt_q        <= zcnt_d;
      fzc_q         <= fzc_d;
`endif
    end
  end

  assign in_ready    = en;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign mode_active = mode_active_q;
`ifdef QMU_STATS_EN
  assign frame_zero_cnt = fzc_q;
`else
  assign frame_zero_cnt = '0;
`endif

endmodule

// File: tb/tb_qmu_stream.sv
// Directed vector table plus hand sequences (reset, mid-frame reset, randomly stalled frame) for qmu_stream.
module tb_qmu_stream;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               in_last;
  logic [1:0]         quality_mode;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_last;
  logic [1:0]         mode_active;
  logic [15:0]        frame_zero_cnt;

  always #5 clk = ~clk;

  qmu_stream #(.DATA_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .quality_mode(quality_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .mode_active(mode_active), .frame_zero_cnt(frame_zero_cnt)
  );

  typedef struct {
    logic signed [15:0] x;
    logic               last;
    logic [1:0]         mode;
    logic signed [15:0] y;
    logic [1:0]         ma;
  } vec_t;

  vec_t stim[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic signed [15:0] ref_q(input int x, input int m);
    int h, r;
    if (m == 0) return 16'(x);
    h = 1 << (m - 1);
    if (x >= 0) r = (x + h) / (1 << m);
    else        r = -((-x + h) / (1 << m));
    return 16'(r);
  endfunction

  function automatic vec_t mk(input int x, input bit last, input int mode, input int y, input int ma);
    vec_t v;
    v.x = 16'(x); v.last = last; v.mode = 2'(mode); v.y = 16'(y); v.ma = 2'(ma);
    return v;
  endfunction

  // Streams stim[] through the DUT, comparing every output transfer in order.
  task automatic run(input bit rnd);
    int idx = 0, got = 0, cyc = 0, nexp, first_acc = -1, first_out = -1;
    bit held = 0, pend = 0;
    logic signed [15:0] hd = '0;
    logic hl = 1'b0;
    logic [1:0] pma = '0;
    nexp = stim.size();
    while (got < nexp && cyc < 3000) begin
      @(negedge clk);
      if (pend) begin check("mode_active", mode_active, pma); pend = 0; end
      if (held) check("stall_hold", {out_valid, out_last, out_data}, {1'b1, hl, hd});
      in_valid = (idx < nexp);
      if (idx < nexp) begin
        in_data = stim[idx].x; in_last = stim[idx].last; quality_mode = stim[idx].mode;
      end else begin
        in_data = '0; in_last = 1'b0;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        pma = stim[idx].ma; pend = 1; idx++;
      end
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = cyc;
        check("out_data", out_data, stim[got].y);
        check("out_last", out_last, stim[got].last);
        got++;
      end
      held = out_valid && !out_ready;
      hd = out_data; hl = out_last;
      cyc++;
    end
    if (got < nexp) check("timeout_outputs", got, nexp);
    if (!rnd) check("latency", first_out - first_acc, 2);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    #1;
    if (pend) check("mode_active", mode_active, pma);
    check("drained", out_valid, 0);
    stim.delete();
  endtask

  vec_t tbl[$];
  int   exp_zero;
  int   m0, xr;

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'sd5; in_last = 1'b0;
    quality_mode = 2'd3; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_mode_active", mode_active, 0);
    check("rst_frame_zero_cnt", frame_zero_cnt, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // x, last, quality_mode, expected y, expected mode_active
    tbl = '{
      mk(5, 0, 1, 3, 1), mk(-5, 0, 1, -3, 1), mk(4, 0, 1, 2, 1), mk(1, 1, 1, 1, 1),
      mk(32767, 0, 3, 4096, 3), mk(-32768, 1, 3, -4096, 3),
      mk(7, 0, 2, 2, 2), mk(-7, 0, 2, -2, 2), mk(1, 0, 2, 0, 2), mk(-1, 1, 2, 0, 2),
      mk(8, 0, 2, 2, 2), mk(8, 0, 0, 2, 2), mk(8, 1, 0, 2, 2), mk(8, 1, 0, 8, 0),
      mk(1, 0, 2, 0, 2), mk(-1, 0, 2, 0, 2), mk(2, 0, 2, 1, 2), mk(0, 0, 2, 0, 2), mk(9, 1, 2, 2, 2)
    };
    for (int i = 0; i < tbl.size(); i++) stim.push_back(tbl[i]);
    run(1'b0);
`ifdef QMU_STATS_EN
    exp_zero = 2;
`else
    exp_zero = 0;
`endif
    check("frame_zero_cnt", frame_zero_cnt, exp_zero);

    // 64-beat frame under random backpressure; mid-frame mode changes must be ignored
    m0 = int'($urandom_range(1, 3));
    exp_zero = 0;
    for (int i = 0; i < 64; i++) begin
      xr = int'($signed(16'($urandom)));
      if (i == 5) xr = -32768;
      if (i == 6) xr = 32767;
      if (i % 7 == 3) xr = int'($urandom_range(0, 2)) - 1;
      if (xr != 0 && ref_q(xr, m0) == 0) exp_zero++;
      stim.push_back(mk(xr, i == 63, (i == 0) ? m0 : int'($urandom_range(0, 3)), int'(ref_q(xr, m0)), m0));
    end
    run(1'b1);
`ifndef QMU_STATS_EN
    exp_zero = 0;
`endif
    check("frame_zero_cnt_rand", frame_zero_cnt, exp_zero);

    // Reset with two beats of an unfinished mode-3 frame in flight
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'sd100; in_last = 1'b0; quality_mode = 2'd3;
    @(negedge clk);
    in_data = 16'sd200;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_mode_active", mode_active, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stim.push_back(mk(5, 1, 1, 3, 1));
    run(1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
